// File: rtl/nrow_game_pkg.sv
// Shared types and codes for the N-in-a-row game engine.
// Cell/result encodings, check directions and FSM states.
package nrow_game_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] RES_PLAY = 2'b00;
  localparam logic [1:0] RES_XWIN = 2'b01;
  localparam logic [1:0] RES_OWIN = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D,
    DIR_A
  } dir_e;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_CHK_H,
    ST_CHK_V,
    ST_CHK_D,
    ST_CHK_A,
    ST_JUDGE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/nrow_game_engine_line_count.sv
// Combinational run-length counter through one cell along one direction.
// Counts both sides, bounded per side and clipped at board edges.
module nrow_line_count
  import nrow_game_pkg::*;
#(
  parameter int COLS    = 3,
  parameter int ROWS    = 3,
  parameter int WIN_LEN = 3,
  parameter int IDX_W   = $clog2(COLS*ROWS),
  parameter int CNT_W   = $clog2(WIN_LEN+1)
) (
  input  logic [2*COLS*ROWS-1:0] board,
  input  logic [IDX_W-1:0]       origin,
  input  dir_e                   dir,
  input  logic [1:0]             colour,
  output logic [CNT_W-1:0]       run
);

  localparam int CELLS = COLS*ROWS;

  // off-board coordinates read as empty so runs never wrap
  function automatic logic [1:0] cell_at(
    input logic [2*CELLS-1:0] b,
    input int                 r,
    input int                 c
  );
    logic [1:0] v;
    v = CELL_EMPTY;
    if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
      for (int i = 0; i < CELLS; i++) begin
        if (i == r*COLS + c) v = b[2*i +: 2];
      end
    end
    return v;
  endfunction

  always_comb begin : cnt
    int   r0;
    int   c0;
    int   dr;
    int   dc;
    int   n;
    logic fwd;
    logic bwd;
    r0 = int'(origin) / COLS;
    c0 = int'(origin) % COLS;
    dr = 0;
    dc = 1;
    unique case (dir)
      DIR_H: begin dr = 0; dc = 1;  end
      DIR_V: begin dr = 1; dc = 0;  end
      DIR_D: begin dr = 1; dc = 1;  end
      DIR_A: begin dr = 1; dc = -1; end
    endcase
    n   = 1;
    fwd = 1'b1;
    bwd = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      fwd = fwd &&
        (cell_at(board, r0 + k*dr, c0 + k*dc) == colour);
      bwd = bwd &&
        (cell_at(board, r0 - k*dr, c0 - k*dc) == colour);
      n = n + int'(fwd) + int'(bwd);
    end
    run = (n >= WIN_LEN) ? CNT_W'(WIN_LEN) : CNT_W'(n);
  end

endmodule

// File: rtl/nrow_game_engine.sv
// COLS x ROWS N-in-a-row board, move handshake and win/draw judge.
// One line counter is time-shared over four check states.
module nrow_game_engine
  import nrow_game_pkg::*;
#(
  parameter int COLS    = 3,
  parameter int ROWS    = 3,
  parameter int WIN_LEN = 3,
  parameter int IDX_W   = $clog2(COLS*ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   move_valid,
  input  logic [IDX_W-1:0]       move_idx,
  output logic                   move_ready,
  output logic                   move_reject,
  output logic [2*COLS*ROWS-1:0] board,
  output logic                   turn_o,
  output logic [1:0]             result,
  output logic                   game_over,
  output logic [IDX_W:0]         move_count
);

  localparam int CELLS = COLS*ROWS;
  localparam int CNT_W = $clog2(WIN_LEN+1);

  state_e           state;
  state_e           state_n;
  logic [IDX_W-1:0] last_idx;
  logic             hit;
  logic             accept;
  logic             rej;
  logic             chk;
  logic             judge;
  logic             full;
  logic             legal;
  logic [1:0]       cur;
  logic [1:0]       colour;
  dir_e             dir;
  logic [CNT_W-1:0] run;

  assign colour     = turn_o ? CELL_O : CELL_X;
  assign full       = (int'(move_count) == CELLS);
  assign move_ready = (state == ST_WAIT);
  assign game_over  = (result != RES_PLAY);

  always_comb begin
    cur = CELL_EMPTY;
    for (int i = 0; i < CELLS; i++) begin
      if (int'(move_idx) == i) cur = board[2*i +: 2];
    end
  end

  assign legal = (int'(move_idx) < CELLS) &&
                 (cur == CELL_EMPTY);

  nrow_line_count #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .WIN_LEN (WIN_LEN),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .board  (board),
    .origin (last_idx),
    .dir    (dir),
    .colour (colour),
    .run    (run)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_WAIT;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    rej     = 1'b0;
    chk     = 1'b0;
    judge   = 1'b0;
    dir     = DIR_H;
    unique case (state)
      ST_WAIT: begin
        if (move_valid) begin
          if (legal) begin
            accept  = 1'b1;
            state_n = ST_CHK_H;
          end else begin
            rej = 1'b1;
          end
        end
      end
      ST_CHK_H: begin
        chk     = 1'b1;
        dir     = DIR_H;
        state_n = ST_CHK_V;
      end
      ST_CHK_V: begin
        chk     = 1'b1;
        dir     = DIR_V;
        state_n = ST_CHK_D;
      end
      ST_CHK_D: begin
        chk     = 1'b1;
        dir     = DIR_D;
        state_n = ST_CHK_A;
      end
      ST_CHK_A: begin
        chk     = 1'b1;
        dir     = DIR_A;
        state_n = ST_JUDGE;
      end
      ST_JUDGE: begin
        judge   = 1'b1;
        state_n = (hit || full) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: state_n = ST_DONE;
      default: state_n = ST_WAIT;
    endcase
    // a clear request overrides any move in flight
    if (new_game) begin
      state_n = ST_WAIT;
      accept  = 1'b0;
      rej     = 1'b0;
      chk     = 1'b0;
      judge   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board       <= '0;
      turn_o      <= 1'b0;
      result      <= RES_PLAY;
      move_count  <= '0;
      move_reject <= 1'b0;
      hit         <= 1'b0;
      last_idx    <= '0;
    end else begin
      move_reject <= rej;
      if (new_game) begin
        board      <= '0;
        turn_o     <= 1'b0;
        result     <= RES_PLAY;
        move_count <= '0;
        hit        <= 1'b0;
      end else begin
        if (accept) begin
          board[{move_idx, 1'b0} +: 2] <= colour;
          move_count <= move_count + (IDX_W+1)'(1);
          last_idx   <= move_idx;
          hit        <= 1'b0;
        end
        if (chk && int'(run) >= WIN_LEN) hit <= 1'b1;
        // a win on the filling move outranks the draw
        if (judge) begin
          if (hit)       result <= turn_o ? RES_OWIN : RES_XWIN;
          else if (full) result <= RES_DRAW;
          else           turn_o <= ~turn_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_nrow_game_engine.sv
// Directed bench: default 3x3 engine and a 5x4 / 4-in-a-row engine.
// Expected values are hand-derived from the move sequences.
module tb_nrow_game_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic       sel = 1'b0;
  logic [4:0] move_idx = '0;
  logic       mv_a;
  logic       mv_b;

  logic        rdy_a, rej_a, turn_a, over_a;
  logic [17:0] board_a;
  logic [1:0]  res_a;
  logic [4:0]  cnt_a;

  logic        rdy_b, rej_b, turn_b, over_b;
  logic [39:0] board_b;
  logic [1:0]  res_b;
  logic [5:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  int s_win[5]  = '{0, 3, 1, 4, 2};
  int s_draw[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int s_last[9] = '{0, 1, 4, 2, 5, 3, 6, 7, 8};
  int s_anti[8] = '{0, 3, 5, 7, 10, 11, 1, 15};
  int s_wrap[7] = '{3, 10, 4, 11, 5, 12, 6};

  always #5 clk = ~clk;

  assign mv_a = move_valid & ~sel;
  assign mv_b = move_valid & sel;

  nrow_game_engine u_a (
    .clk         (clk),
    .rst         (rst),
    .new_game    (new_game),
    .move_valid  (mv_a),
    .move_idx    (move_idx[3:0]),
    .move_ready  (rdy_a),
    .move_reject (rej_a),
    .board       (board_a),
    .turn_o      (turn_a),
    .result      (res_a),
    .game_over   (over_a),
    .move_count  (cnt_a)
  );

  nrow_game_engine #(
    .COLS    (5),
    .ROWS    (4),
    .WIN_LEN (4)
  ) u_b (
    .clk         (clk),
    .rst         (rst),
    .new_game    (new_game),
    .move_valid  (mv_b),
    .move_idx    (move_idx),
    .move_ready  (rdy_b),
    .move_reject (rej_b),
    .board       (board_b),
    .turn_o      (turn_b),
    .result      (res_b),
    .game_over   (over_b),
    .move_count  (cnt_b)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic mv(input int i);
    @(negedge clk);
    move_valid = 1'b1;
    move_idx   = 5'(i);
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic play(input int i);
    mv(i);
    repeat (5) @(negedge clk);
  endtask

  task automatic ng();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_board", 64'(board_a), 64'h0);
    check("rst_turn", 64'(turn_a), 64'h0);
    check("rst_res", 64'(res_a), 64'h0);
    check("rst_cnt", 64'(cnt_a), 64'h0);
    check("rst_rej", 64'(rej_a), 64'h0);
    check("rst_board_b", 64'(board_b), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rdy_a_after_rst", 64'(rdy_a), 64'h1);
    check("rdy_b_after_rst", 64'(rdy_b), 64'h1);

    // X takes the top row
    foreach (s_win[i]) play(s_win[i]);
    check("win_res", 64'(res_a), 64'h1);
    check("win_over", 64'(over_a), 64'h1);
    check("win_rdy", 64'(rdy_a), 64'h0);
    check("win_board", 64'(board_a), 64'h295);
    mv(5);
    check("done_no_rej", 64'(rej_a), 64'h0);
    repeat (2) @(negedge clk);
    check("done_frozen", 64'(board_a), 64'h295);
    check("done_cnt", 64'(cnt_a), 64'h5);

    // illegal moves
    ng();
    check("ng_board", 64'(board_a), 64'h0);
    check("ng_res", 64'(res_a), 64'h0);
    check("ng_rdy", 64'(rdy_a), 64'h1);
    play(4);
    mv(4);
    check("occ_rej", 64'(rej_a), 64'h1);
    @(negedge clk);
    check("occ_rej_pulse", 64'(rej_a), 64'h0);
    check("occ_cell", 64'(board_a[9:8]), 64'h1);
    check("occ_turn", 64'(turn_a), 64'h1);
    check("occ_cnt", 64'(cnt_a), 64'h1);
    mv(9);
    check("oob_rej", 64'(rej_a), 64'h1);
    check("oob_board", 64'(board_a), 64'h100);

    // draw
    ng();
    foreach (s_draw[i]) play(s_draw[i]);
    check("draw_res", 64'(res_a), 64'h3);
    check("draw_cnt", 64'(cnt_a), 64'h9);
    check("draw_turn", 64'(turn_a), 64'h0);
    check("draw_over", 64'(over_a), 64'h1);

    // win on the filling move
    ng();
    foreach (s_last[i]) play(s_last[i]);
    check("lastwin_res", 64'(res_a), 64'h1);
    check("lastwin_cnt", 64'(cnt_a), 64'h9);

    // new_game with move_valid while in CHK_D
    ng();
    mv(0);
    @(negedge clk);
    @(negedge clk);
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_idx   = 5'd5;
    @(negedge clk);
    new_game   = 1'b0;
    move_valid = 1'b0;
    check("ngchk_board", 64'(board_a), 64'h0);
    check("ngchk_turn", 64'(turn_a), 64'h0);
    check("ngchk_res", 64'(res_a), 64'h0);
    check("ngchk_rdy", 64'(rdy_a), 64'h1);
    check("ngchk_cnt", 64'(cnt_a), 64'h0);

    // async reset mid-check
    mv(0);
    @(negedge clk);
    check("pre_rst_cnt", 64'(cnt_a), 64'h1);
    rst = 1'b0;
    #1;
    check("arst_board", 64'(board_a), 64'h0);
    check("arst_cnt", 64'(cnt_a), 64'h0);
    check("arst_turn", 64'(turn_a), 64'h0);
    check("arst_res", 64'(res_a), 64'h0);
    check("arst_rdy", 64'(rdy_a), 64'h1);
    @(negedge clk);
    rst = 1'b1;

    // 5x4, 4-in-a-row: O anti-diagonal
    sel = 1'b1;
    ng();
    foreach (s_anti[i]) play(s_anti[i]);
    check("b_anti_res", 64'(res_b), 64'h2);
    check("b_anti_over", 64'(over_b), 64'h1);
    check("b_anti_rdy", 64'(rdy_b), 64'h0);
    check("b_anti_c15", 64'(board_b[31:30]), 64'h2);

    // X run 3,4,5,6 crosses a row edge
    ng();
    foreach (s_wrap[i]) play(s_wrap[i]);
    check("b_wrap_res", 64'(res_b), 64'h0);
    check("b_wrap_turn", 64'(turn_b), 64'h1);
    check("b_wrap_cnt", 64'(cnt_b), 64'h7);
    check("b_wrap_rdy", 64'(rdy_b), 64'h1);
    check("b_wrap_c6", 64'(board_b[13:12]), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
